// File: rtl/rv_pkg.sv
// Shared RV32I decode constants used by the ALU and the core's decoder.
package rv_pkg;

  localparam int XLEN = 32;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;

  localparam logic [2:0] F3_ADD  = 3'b000;
  localparam logic [2:0] F3_SLL  = 3'b001;
  localparam logic [2:0] F3_SLT  = 3'b010;
  localparam logic [2:0] F3_SLTU = 3'b011;
  localparam logic [2:0] F3_XOR  = 3'b100;
  localparam logic [2:0] F3_SR   = 3'b101;
  localparam logic [2:0] F3_OR   = 3'b110;
  localparam logic [2:0] F3_AND  = 3'b111;

endpackage

// File: rtl/rv_alu_shifter.sv
// Combinational barrel shifter for SLL/SRL/SRA and their immediate forms.
module rv_alu_shifter
  import rv_pkg::*;
(
  input  logic [XLEN-1:0] i_value,
  input  logic [4:0]      i_shamt,
  input  logic            i_right,
  input  logic            i_arith,
  output logic [XLEN-1:0] o_value
);

  always_comb begin
    o_value = i_value << i_shamt;
    if (i_right) begin
      if (i_arith) begin
        o_value = $signed(i_value) >>> i_shamt;
      end else begin
        o_value = i_value >> i_shamt;
      end
    end
  end

endmodule

// File: rtl/rv_alu.sv
// Registered RV32I integer ALU: samples OP/OP-IMM fields each edge and
// registers the result on rd, with comp marking a freshly computed value.
module rv_alu #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [2:0]      funct3,
  input  logic            modbit,
  input  logic [XLEN-1:0] imm,
  input  logic [6:0]      opcode,
  input  logic [XLEN-1:0] rs1,
  input  logic [XLEN-1:0] rs2,
  output logic [XLEN-1:0] rd,
  output logic            comp
);

  import rv_pkg::*;

  logic            w_isOp;
  logic            w_isOpImm;
  logic [XLEN-1:0] w_b;
  logic [XLEN-1:0] w_sum;
  logic            w_ltSigned;
  logic            w_ltUnsigned;
  logic [XLEN-1:0] w_shifted;
  logic [XLEN-1:0] w_result;
  logic [XLEN-1:0] r_rd;
  logic            r_comp;

  assign w_isOp    = (opcode == OPC_OP);
  assign w_isOpImm = (opcode == OPC_OP_IMM);
  assign w_b       = w_isOp ? rs2 : imm;

  // modbit only selects SUB for register-register; ADDI has no SUBI form.
  assign w_sum = (w_isOp && modbit) ? (rs1 - w_b) : (rs1 + w_b);

  assign w_ltSigned   = ($signed(rs1) < $signed(w_b));
  assign w_ltUnsigned = (rs1 < w_b);

  rv_alu_shifter u_shifter (
    .i_value (rs1),
    .i_shamt (w_b[4:0]),
    .i_right (funct3 == F3_SR),
    .i_arith (modbit),
    .o_value (w_shifted)
  );

  always_comb begin
    w_result = w_sum;
    case (funct3)
      F3_ADD:  w_result = w_sum;
      F3_SLL:  w_result = w_shifted;
      F3_SLT:  w_result = {{(XLEN-1){1'b0}}, w_ltSigned};
      F3_SLTU: w_result = {{(XLEN-1){1'b0}}, w_ltUnsigned};
      F3_XOR:  w_result = rs1 ^ w_b;
      F3_SR:   w_result = w_shifted;
      F3_OR:   w_result = rs1 | w_b;
      F3_AND:  w_result = rs1 & w_b;
      default: w_result = w_sum;
    endcase
  end

  // Non-ALU opcodes leave rd untouched so the core can still read the last result.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_rd   <= '0;
      r_comp <= 1'b0;
    end else if (w_isOp || w_isOpImm) begin
      r_rd   <= w_result;
      r_comp <= 1'b1;
    end else begin
      r_comp <= 1'b0;
    end
  end

  assign rd   = r_rd;
  assign comp = r_comp;

endmodule

// File: tb/tb_rv_alu.sv
// Directed, table-driven bench for rv_alu with hand-computed expectations.
module tb_rv_alu;

  localparam logic [6:0] OP     = 7'b0110011;
  localparam logic [6:0] OPIMM  = 7'b0010011;
  localparam logic [6:0] LOAD   = 7'b0000011;

  typedef struct {
    string       name;
    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic        modbit;
    logic [31:0] rs1;
    logic [31:0] rs2;
    logic [31:0] imm;
    logic [31:0] expRd;
  } vec_t;

  logic        clk;
  logic        reset;
  logic [2:0]  funct3;
  logic        modbit;
  logic [31:0] imm;
  logic [6:0]  opcode;
  logic [31:0] rs1;
  logic [31:0] rs2;
  logic [31:0] rd;
  logic        comp;

  int testsRun;
  int testsFailed;
  vec_t vecs[$];

  rv_alu #(.XLEN(32)) dut (
    .clk    (clk),
    .reset  (reset),
    .funct3 (funct3),
    .modbit (modbit),
    .imm    (imm),
    .opcode (opcode),
    .rs1    (rs1),
    .rs2    (rs2),
    .rd     (rd),
    .comp   (comp)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic vec_t mk(string n, logic [6:0] op, logic [2:0] f3, logic m,
                              logic [31:0] a, logic [31:0] b, logic [31:0] i,
                              logic [31:0] e);
    vec_t v;
    v.name = n; v.opcode = op; v.funct3 = f3; v.modbit = m;
    v.rs1 = a; v.rs2 = b; v.imm = i; v.expRd = e;
    return v;
  endfunction

  // Drive on the falling edge, then step past the next rising edge to sample.
  task automatic applyStimulus(logic rst, logic [6:0] op, logic [2:0] f3, logic m,
                               logic [31:0] a, logic [31:0] b, logic [31:0] i);
    @(negedge clk);
    reset = rst; opcode = op; funct3 = f3; modbit = m;
    rs1 = a; rs2 = b; imm = i;
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(string n, logic [31:0] expRd, logic expComp);
    testsRun++;
    if (rd !== expRd) begin
      testsFailed++;
      $display("[TB] FAIL %s rd: got %08h expected %08h", n, rd, expRd);
    end
    testsRun++;
    if (comp !== expComp) begin
      testsFailed++;
      $display("[TB] FAIL %s comp: got %0b expected %0b", n, comp, expComp);
    end
  endtask

  initial begin
    testsRun = 0;
    testsFailed = 0;
    reset = 1'b1; opcode = OP; funct3 = 3'b000; modbit = 1'b0;
    rs1 = '0; rs2 = '0; imm = '0;

    vecs.push_back(mk("sub_neg",   OP,    3'b000, 1'b1, 32'd3,        32'd5,        32'd0,        32'hFFFFFFFE));
    vecs.push_back(mk("add",       OP,    3'b000, 1'b0, 32'd3,        32'd5,        32'd0,        32'd8));
    vecs.push_back(mk("addi_wrap", OPIMM, 3'b000, 1'b1, 32'hFFFFFFFF, 32'd0,        32'd1,        32'd0));
    vecs.push_back(mk("addi_bsel", OPIMM, 3'b000, 1'b0, 32'd10,       32'd100,      32'hFFFFFFFE, 32'd8));
    vecs.push_back(mk("slt",       OP,    3'b010, 1'b0, 32'hFFFFFFFF, 32'd1,        32'd0,        32'd1));
    vecs.push_back(mk("sltu",      OP,    3'b011, 1'b0, 32'hFFFFFFFF, 32'd1,        32'd0,        32'd0));
    vecs.push_back(mk("sltiu",     OPIMM, 3'b011, 1'b0, 32'd5,        32'd0,        32'hFFFFFFFF, 32'd1));
    vecs.push_back(mk("slti",      OPIMM, 3'b010, 1'b0, 32'd5,        32'd0,        32'hFFFFFFFF, 32'd0));
    vecs.push_back(mk("sra31",     OP,    3'b101, 1'b1, 32'h80000000, 32'd31,       32'd0,        32'hFFFFFFFF));
    vecs.push_back(mk("srl31",     OP,    3'b101, 1'b0, 32'h80000000, 32'd31,       32'd0,        32'd1));
    vecs.push_back(mk("slli_5bit", OPIMM, 3'b001, 1'b0, 32'd1,        32'd0,        32'h23,       32'd8));
    vecs.push_back(mk("srai",      OPIMM, 3'b101, 1'b1, 32'hF0000000, 32'd0,        32'd4,        32'hFF000000));
    vecs.push_back(mk("srli",      OPIMM, 3'b101, 1'b0, 32'hF0000000, 32'd0,        32'd4,        32'h0F000000));
    vecs.push_back(mk("sll",       OP,    3'b001, 1'b0, 32'h0000000F, 32'd4,        32'd0,        32'h000000F0));
    vecs.push_back(mk("sll_zero",  OP,    3'b001, 1'b0, 32'h12345678, 32'd0,        32'd0,        32'h12345678));
    vecs.push_back(mk("srl_hibits",OP,    3'b101, 1'b0, 32'h00000100, 32'h24,       32'd0,        32'h00000010));
    vecs.push_back(mk("xor",       OP,    3'b100, 1'b0, 32'hF0F0F0F0, 32'h0FF00FF0, 32'd0,        32'hFF00FF00));
    vecs.push_back(mk("or",        OP,    3'b110, 1'b0, 32'hF0F0F0F0, 32'h0FF00FF0, 32'd0,        32'hFFF0FFF0));
    vecs.push_back(mk("and",       OP,    3'b111, 1'b0, 32'hF0F0F0F0, 32'h0FF00FF0, 32'd0,        32'h00F000F0));
    vecs.push_back(mk("xori",      OPIMM, 3'b100, 1'b0, 32'hFFFF0000, 32'd0,        32'hFFFFFFFF, 32'h0000FFFF));
    vecs.push_back(mk("andi",      OPIMM, 3'b111, 1'b0, 32'h12345678, 32'hFFFFFFFF, 32'h000000F0, 32'h00000070));

    // Reset wins over a valid ADD, then the same ADD computes normally.
    applyStimulus(1'b1, OP, 3'b000, 1'b0, 32'd5, 32'd7, 32'd0);
    checkOutput("reset", 32'd0, 1'b0);
    applyStimulus(1'b0, OP, 3'b000, 1'b0, 32'd5, 32'd7, 32'd0);
    checkOutput("post_reset_add", 32'd12, 1'b1);

    // A non-ALU opcode holds rd and drops comp; the next OP recomputes.
    applyStimulus(1'b0, LOAD, 3'b000, 1'b0, 32'd99, 32'd1, 32'd4);
    checkOutput("load_hold", 32'd12, 1'b0);
    applyStimulus(1'b0, OP, 3'b000, 1'b0, 32'd1, 32'd2, 32'd0);
    checkOutput("op_after_load", 32'd3, 1'b1);

    foreach (vecs[k]) begin
      applyStimulus(1'b0, vecs[k].opcode, vecs[k].funct3, vecs[k].modbit,
                    vecs[k].rs1, vecs[k].rs2, vecs[k].imm);
      checkOutput(vecs[k].name, vecs[k].expRd, 1'b1);
    end

    // Reset clears a non-zero result mid-stream.
    applyStimulus(1'b1, OP, 3'b110, 1'b0, 32'hFFFFFFFF, 32'd1, 32'd0);
    checkOutput("reset_clears", 32'd0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
